// File: rtl/bcd_alu_sequencer.sv
// Multi-cycle packed-BCD add/subtract/multiply engine built around one shared
// digit adder/subtractor; one digit is processed per clock.
module bcd_alu_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic [1:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic                  overflow,
    output logic                  negative,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL_SHIFT, MUL_ADD, DONE} state_t;

    state_t                 state, state_nx;
    logic [DIGITS-1:0][3:0] a_reg, b_reg, acc;
    logic                   is_sub, is_mul, carry;
    logic [IW-1:0]          idx, bpos;
    logic [3:0]             rep;
    logic [3:0]             dx, dy, dout;
    logic                   cout;
    logic [4:0]             sum, diff;
    logic                   bad_in, swap;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    assign bad_in = (op == 2'b11) || has_bad_digit(a_bcd) || has_bad_digit(b_bcd);
    // Packed-BCD ordering matches binary ordering, so a plain compare decides the swap.
    assign swap   = (op == 2'b01) && (a_bcd < b_bcd);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // The error path spends one pass through ADDSUB (index preloaded to the last
    // digit, writes suppressed) so it reports after a single cycle of work.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = (op == 2'b10 && !bad_in) ? MUL_SHIFT : ADDSUB;
            ADDSUB:    if (idx == LAST) state_nx = DONE;
            MUL_SHIFT: begin
                if (b_reg[bpos] != 4'd0) state_nx = MUL_ADD;
                else if (bpos == '0)     state_nx = DONE;
            end
            MUL_ADD:   if (idx == LAST && rep == 4'd1) state_nx = (bpos == '0) ? DONE : MUL_SHIFT;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    assign result_bcd = acc;

    always_comb begin
        dx   = is_mul ? acc[idx]   : a_reg[idx];
        dy   = is_mul ? a_reg[idx] : b_reg[idx];
        sum  = {1'b0, dx} + {1'b0, dy} + {4'b0, carry};
        diff = {1'b0, dx} - {1'b0, dy} - {4'b0, carry};
        dout = sum[3:0];
        cout = 1'b0;
        if (is_sub) begin
            if (diff[4]) begin
                dout = diff[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                dout = diff[3:0];
            end
        end else if (sum > 5'd9) begin
            dout = 4'(sum - 5'd10);
            cout = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            is_sub   <= 1'b0;
            is_mul   <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            bpos     <= '0;
            rep      <= '0;
            overflow <= 1'b0;
            negative <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg    <= swap ? b_bcd : a_bcd;
                    b_reg    <= swap ? a_bcd : b_bcd;
                    is_sub   <= (op == 2'b01);
                    is_mul   <= (op == 2'b10) && !bad_in;
                    err      <= bad_in;
                    negative <= swap && !bad_in;
                    overflow <= 1'b0;
                    acc      <= '0;
                    carry    <= 1'b0;
                    idx      <= bad_in ? LAST : '0;
                    bpos     <= LAST;
                    rep      <= '0;
                end
                ADDSUB: begin
                    if (!err) begin
                        acc[idx] <= dout;
                        if (idx == LAST && cout && !is_sub) overflow <= 1'b1;
                    end
                    carry <= (idx == LAST) ? 1'b0 : cout;
                    idx   <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                MUL_SHIFT: begin
                    if (acc[DIGITS-1] != 4'd0) overflow <= 1'b1;
                    acc   <= {acc[DIGITS-2:0], 4'h0};
                    rep   <= b_reg[bpos];
                    idx   <= '0;
                    carry <= 1'b0;
                    if (b_reg[bpos] == 4'd0 && bpos != '0) bpos <= bpos - 1'b1;
                end
                MUL_ADD: begin
                    acc[idx] <= dout;
                    if (idx == LAST) begin
                        if (cout) overflow <= 1'b1;
                        carry <= 1'b0;
                        idx   <= '0;
                        rep   <= rep - 1'b1;
                        if (rep == 4'd1 && bpos != '0) bpos <= bpos - 1'b1;
                    end else begin
                        carry <= cout;
                        idx   <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Directed self-checking bench for bcd_alu_sequencer (DIGITS=4) with
// hand-computed results, flags and latencies.
module tb_bcd_alu_sequencer;

    localparam int W     = 16;
    localparam int LIMIT = 200;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_bcd, b_bcd;
    logic [1:0]   op;
    logic         busy, done, overflow, negative, err;
    logic [W-1:0] result_bcd;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_alu_sequencer #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd),
        .op(op), .busy(busy), .done(done), .result_bcd(result_bcd),
        .overflow(overflow), .negative(negative), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts edges after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        int cnt = 0;
        while (done !== 1'b1 && cnt < LIMIT) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        lat = (done === 1'b1) ? cnt : -1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o, output int lat);
        @(negedge clk);
        a_bcd = a; b_bcd = b; op = o; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; a_bcd = '0; b_bcd = '0; op = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, result_bcd, overflow, negative, err} !== 21'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h want 0", {busy, done, result_bcd, overflow, negative, err});
        end
        rst = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        do_op(16'h0999, 16'h0001, 2'b00, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("[TB] FAIL add_latency: got %0d want 4", lat); end
        n_checks++;
        if ({busy, result_bcd, overflow, negative, err} !== {1'b1, 16'h1000, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL add_result: got %h/%b%b%b busy=%b want 1000/000 busy=1", result_bcd, overflow, negative, err, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("[TB] FAIL done_one_cycle: got busy,done=%b%b want 00", busy, done); end
        @(negedge clk);
        n_checks++;
        if (result_bcd !== 16'h1000) begin n_fail++; $display("[TB] FAIL add_hold: got %h want 1000", result_bcd); end
    endtask

    task automatic test_add_overflow;
        int lat;
        do_op(16'h9999, 16'h0001, 2'b00, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("[TB] FAIL addovf_latency: got %0d want 4", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0000, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL addovf_result: got %h/%b%b%b want 0000/100", result_bcd, overflow, negative, err);
        end
    endtask

    task automatic test_sub;
        int lat;
        do_op(16'h0012, 16'h0345, 2'b01, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("[TB] FAIL subneg_latency: got %0d want 4", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0333, 3'b010}) begin
            n_fail++;
            $display("[TB] FAIL subneg_result: got %h/%b%b%b want 0333/010", result_bcd, overflow, negative, err);
        end
        do_op(16'h0345, 16'h0345, 2'b01, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("[TB] FAIL subeq_latency: got %0d want 4", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0000, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL subeq_result: got %h/%b%b%b want 0000/000", result_bcd, overflow, negative, err);
        end
        do_op(16'h0345, 16'h0012, 2'b01, lat);
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0333, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL subpos_result: got %h/%b%b%b want 0333/000", result_bcd, overflow, negative, err);
        end
    endtask

    task automatic test_mul;
        int lat;
        do_op(16'h0012, 16'h0012, 2'b10, lat);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d want 16", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0144, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL mul_result: got %h/%b%b%b want 0144/000", result_bcd, overflow, negative, err);
        end
        do_op(16'h0100, 16'h0100, 2'b10, lat);
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("[TB] FAIL mulovf_latency: got %0d want 8", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0000, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL mulovf_result: got %h/%b%b%b want 0000/100", result_bcd, overflow, negative, err);
        end
        do_op(16'h0025, 16'h0304, 2'b10, lat);
        n_checks++;
        if ({lat, result_bcd, overflow} !== {32'd32, 16'h7600, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL mul3_result: got lat=%0d %h ovf=%b want lat=32 7600 ovf=0", lat, result_bcd, overflow);
        end
    endtask

    task automatic test_err;
        int lat;
        do_op(16'h0012, 16'h0034, 2'b11, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("[TB] FAIL errop_latency: got %0d want 1", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0000, 3'b001}) begin
            n_fail++;
            $display("[TB] FAIL errop_result: got %h/%b%b%b want 0000/001", result_bcd, overflow, negative, err);
        end
        do_op(16'h00A1, 16'h0001, 2'b00, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("[TB] FAIL errdig_latency: got %0d want 1", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0000, 3'b001}) begin
            n_fail++;
            $display("[TB] FAIL errdig_result: got %h/%b%b%b want 0000/001", result_bcd, overflow, negative, err);
        end
        do_op(16'h0001, 16'h0F00, 2'b10, lat);
        n_checks++;
        if ({lat, result_bcd, err} !== {32'd1, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL errmulb_result: got lat=%0d %h err=%b want lat=1 0000 err=1", lat, result_bcd, err);
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        int extra = 0;
        @(negedge clk);
        a_bcd = 16'h0012; b_bcd = 16'h0012; op = 2'b10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_bcd = 16'h0003; b_bcd = 16'h0002; op = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        if (lat >= 0) lat = lat + 2;
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("[TB] FAIL busy_start_latency: got %0d want 16", lat); end
        n_checks++;
        if ({result_bcd, overflow, negative, err} !== {16'h0144, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL busy_start_result: got %h/%b%b%b want 0144/000", result_bcd, overflow, negative, err);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("[TB] FAIL busy_start_extra: got %0d extra busy/done cycles want 0", extra); end
    endtask

    task automatic test_reset_mid_op;
        int lat;
        @(negedge clk);
        a_bcd = 16'h0012; b_bcd = 16'h0012; op = 2'b10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if ({busy, done, result_bcd, overflow, negative, err} !== 21'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_state: got %h want 0", {busy, done, result_bcd, overflow, negative, err});
        end
        do_op(16'h0012, 16'h0034, 2'b00, lat);
        n_checks++;
        if ({lat, result_bcd, overflow, negative, err} !== {32'd4, 16'h0046, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL midreset_restart: got lat=%0d %h/%b%b%b want lat=4 0046/000", lat, result_bcd, overflow, negative, err);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_add_overflow;
        test_sub;
        test_mul;
        test_err;
        test_start_while_busy;
        test_reset_mid_op;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_alu_sequencer.md
Name: bcd_alu_sequencer

Overview:
- Multi-cycle BCD arithmetic engine. It sits between the calculator entry FSM and the result display.
- Accepts two packed-BCD operands and a 2-bit operation on a start pulse.
- Computes add, subtract or multiply one digit per clock using a single shared digit adder/subtractor.
- Returns a registered BCD result with a one-cycle done pulse plus overflow/negative/error flags.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result; bus width W = 4*DIGITS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 sampled at a rising edge of clk resets the block).
- start  in  1  request; accepted only in IDLE.
- a_bcd  in  W  operand A, packed BCD, MS digit in top nibble.
- b_bcd  in  W  operand B, packed BCD.
- op  in  2  operation: 00 add, 01 subtract (A−B), 10 multiply, 11 invalid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result_bcd  out  W  result, packed BCD, low DIGITS digits.
- overflow  out  1  true result exceeds 10^DIGITS−1.
- negative  out  1  subtract result is negative; result_bcd holds the magnitude.
- err  out  1  op==11 or any operand nibble >9.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE. busy, done, overflow, negative and err = 0; result_bcd = 0.
  - Reset applied mid-operation aborts it. No done is issued.
- States: IDLE, CHECK-free accept, ADDSUB, MUL_SHIFT, MUL_ADD, DONE.
- Accept: at an edge with state IDLE and start=1, latch a_bcd, b_bcd and op. Clear overflow, negative and err.
  - Input changes while busy are ignored.
  - start while busy is ignored; it is not queued.
- Latency: k = number of edges from the accepting edge to the edge that enters DONE.
  - err: k=1.
  - add/sub: k=DIGITS.
  - mul: k = DIGITS + DIGITS*S, where S = sum of the digits of B.
- DONE lasts exactly one cycle: done=1, busy=1. Next edge returns to IDLE. start is sampled again from that IDLE cycle.
- Outputs hold their values from DONE until the next accept or reset.
- Error path: if op==11 or any nibble of a_bcd/b_bcd is >9, go straight to DONE with err=1, result_bcd=0, and all other flags 0.
- Add: ADDSUB runs DIGITS cycles, one digit per cycle, LS digit first.
  - Digit sum d = a_i + b_i + carry. If d > 9, the digit is d−10 and carry=1.
  - Carry out of the last digit sets overflow=1. result_bcd = low DIGITS digits.
- Subtract: at accept, compare A and B as unsigned. BCD ordering equals binary ordering of the packed word.
  - If A < B, swap the operands and set negative=1.
  - ADDSUB then computes larger − smaller digit-serially with borrow. A digit below 0 gets +10 and borrow=1.
  - Equal operands give result 0 with negative=0. Overflow is always 0 for subtract.
- Multiply (shift-and-add): accumulator starts at 0. For each digit of B, MS first:
  - MUL_SHIFT, 1 cycle: if the accumulator's top digit is ≠0, set overflow=1. Then shift the accumulator left one digit, inserting 0.
  - MUL_ADD: repeat d times (d = current B digit), adding A into the accumulator with a DIGITS-cycle digit-serial add. A final carry sets overflow=1.
  - A zero B digit skips MUL_ADD.
  - overflow is sticky within the operation. Latency does not change on overflow.
  - result_bcd = final accumulator (low digits).
- Internal counters: a digit index counter 0..DIGITS−1 and a repeat counter 0..9. Both wrap/reload per pass; no other wrap-around exists.

Test Plan:
1. Add: op=00, A=0999, B=0001, start 1 cycle.
   → done exactly 4 edges after accept; result 1000; overflow=0, negative=0, err=0.
2. Add overflow: A=9999, B=0001 → result 0000, overflow=1, done at k=4.
3. Subtract:
   - A=0012, B=0345 → result 0333, negative=1, k=4.
   - Then A=0345, B=0345 → result 0000, negative=0.
4. Multiply:
   - A=0012, B=0012 → result 0144, overflow=0, done at k=16.
   - A=0100, B=0100 → result 0000, overflow=1, k=8.
5. Error:
   - op=11 → err=1, result 0000, done at k=1.
   - A=00A1, op=00 → same response.
6. Control:
   - Pulse start again 2 cycles into a multiply with different operands → ignored; first result is unchanged and no extra done appears.
   - Drive rst=0 for one edge mid-multiply → next cycle busy=0, done=0, all outputs 0; a new start is accepted normally.
